parking_gate_ctrl: RTL and testbench

Gate-side event producer for the parking occupancy counter. It debounces the entry and exit lane loop sensors and decides whether the entry barrier opens, using the counter's availability flags. It drives the barriers and issues the clean `car_entered` / `car_exited` pulses, with their university qualifiers, that the counter consumes. One instance serves one entry lane and one exit lane.

---
 rtl/parking_gate_ctrl.sv | 158 +++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: debounced entry/exit barrier control producing arbitrated car events for the occupancy counter
module parking_gate_ctrl #(
  parameter int DEBOUNCE     = 4,
  parameter int OPEN_TIMEOUT = 64,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             start,
  input  logic             entry_detect,
  input  logic             entry_pass,
  input  logic             entry_is_uni,
  input  logic             exit_detect,
  input  logic             exit_pass,
  input  logic             exit_is_uni,
  input  logic             uni_is_vacated_space,
  input  logic             is_vacated_space,
  output logic             car_entered,
  output logic             is_uni_car_entered,
  output logic             car_exited,
  output logic             is_uni_car_exited,
  output logic             entry_barrier_open,
  output logic             exit_barrier_open,
  output logic             entry_denied,
  output logic             gate_timeout,
  output logic [CNT_W-1:0] denied_count,
  output logic [CNT_W-1:0] timeout_count
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(OPEN_TIMEOUT);

  typedef enum logic [2:0] {E_IDLE, E_DECIDE, E_OPEN, E_DENY, E_REPORT, E_CLEAR} e_state_t;
  typedef enum logic [1:0] {X_IDLE, X_OPEN, X_REPORT, X_CLEAR} x_state_t;

  logic [3:0] raw, s1, s2, filt_q, filt_d, hit;
  logic [DW-1:0] cnt [4];
  e_state_t e_state, e_next;
  x_state_t x_state, x_next;
  logic [TW-1:0] e_timer, x_timer;
  logic e_uni, x_uni, e_to, x_to, e_deny, e_req, x_req, grant_e, grant_x, busy;
  logic det_e, pas_e, det_x, pas_x, rise_e, rise_x;
  logic [CNT_W:0] t_sum;

  assign raw = {exit_pass, exit_detect, entry_pass, entry_detect};

  // FSMs act on the filter's decision in the cycle it is made, saving one cycle of latency
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hit[i]    = (s2[i] != filt_q[i]) && (cnt[i] == DW'(DEBOUNCE - 1));
      filt_d[i] = hit[i] ? s2[i] : filt_q[i];
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      s1     <= '0;
      s2     <= '0;
      filt_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      filt_q <= filt_d;
      for (int i = 0; i < 4; i++) cnt[i] <= (s2[i] != filt_q[i] && !hit[i]) ? cnt[i] + 1'b1 : '0;
    end
  end

  assign det_e  = filt_d[0];
  assign pas_e  = filt_d[1];
  assign det_x  = filt_d[2];
  assign pas_x  = filt_d[3];
  assign rise_e = filt_d[1] & ~filt_q[1];
  assign rise_x = filt_d[3] & ~filt_q[3];

  assign busy    = car_entered | car_exited;
  assign e_req   = e_state == E_REPORT;
  assign x_req   = x_state == X_REPORT;
  assign grant_e = e_req & ~busy;
  assign grant_x = x_req & ~e_req & ~busy;

  always_comb begin
    e_next = e_state;
    e_to   = 1'b0;
    e_deny = 1'b0;
    case (e_state)
      E_IDLE:   if (det_e) e_next = E_DECIDE;
      E_DECIDE: if (e_uni ? uni_is_vacated_space : is_vacated_space) e_next = E_OPEN;
                else begin
                  e_next = E_DENY;
                  e_deny = 1'b1;
                end
      E_DENY:   if (!det_e) e_next = E_IDLE;
      E_OPEN:   if (rise_e) e_next = E_REPORT;
                else if (e_timer == TW'(OPEN_TIMEOUT - 1)) begin
                  e_next = E_CLEAR;
                  e_to   = 1'b1;
                end
      E_REPORT: if (grant_e) e_next = E_CLEAR;
      E_CLEAR:  if (!det_e && !pas_e) e_next = E_IDLE;
      default:  e_next = E_IDLE;
    endcase
  end

  always_comb begin
    x_next = x_state;
    x_to   = 1'b0;
    case (x_state)
      X_IDLE:   if (det_x) x_next = X_OPEN;
      X_OPEN:   if (rise_x) x_next = X_REPORT;
                else if (x_timer == TW'(OPEN_TIMEOUT - 1)) begin
                  x_next = X_CLEAR;
                  x_to   = 1'b1;
                end
      X_REPORT: if (grant_x) x_next = X_CLEAR;
      X_CLEAR:  if (!det_x && !pas_x) x_next = X_IDLE;
      default:  x_next = X_IDLE;
    endcase
  end

  assign t_sum = {1'b0, timeout_count} + (CNT_W + 1)'(e_to) + (CNT_W + 1)'(x_to);

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      e_state            <= E_IDLE;
      x_state            <= X_IDLE;
      e_timer            <= '0;
      x_timer            <= '0;
      e_uni              <= 1'b0;
      x_uni              <= 1'b0;
      car_entered        <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_entered <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      entry_denied       <= 1'b0;
      gate_timeout       <= 1'b0;
      denied_count       <= '0;
      timeout_count      <= '0;
    end else begin
      e_state            <= e_next;
      x_state            <= x_next;
      e_timer            <= (e_state == E_OPEN) ? e_timer + 1'b1 : '0;
      x_timer            <= (x_state == X_OPEN) ? x_timer + 1'b1 : '0;
      e_uni              <= (e_state == E_IDLE && det_e) ? entry_is_uni : e_uni;
      x_uni              <= (x_state == X_IDLE && det_x) ? exit_is_uni : x_uni;
      car_entered        <= grant_e;
      car_exited         <= grant_x;
      is_uni_car_entered <= grant_e ? e_uni : is_uni_car_entered;
      is_uni_car_exited  <= grant_x ? x_uni : is_uni_car_exited;
      entry_denied       <= e_deny;
      gate_timeout       <= e_to | x_to;
      denied_count       <= (e_deny && denied_count != '1) ? denied_count + 1'b1 : denied_count;
      timeout_count      <= t_sum[CNT_W] ? '1 : t_sum[CNT_W-1:0];
    end
  end

  // Decoded straight from state so an asynchronous reset drops the barriers at once
  assign entry_barrier_open = (e_state == E_OPEN) || (e_state == E_REPORT);
  assign exit_barrier_open  = (x_state == X_OPEN) || (x_state == X_REPORT);
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed bench for parking_gate_ctrl with hand-computed expectations
module tb_parking_gate_ctrl;
  logic clk = 1'b0;
  logic start, entry_detect, entry_pass, entry_is_uni, exit_detect, exit_pass, exit_is_uni;
  logic uni_is_vacated_space, is_vacated_space;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic entry_barrier_open, exit_barrier_open, entry_denied, gate_timeout;
  logic [7:0] denied_count, timeout_count;
  int n_checks = 0;
  int n_fail = 0;

  parking_gate_ctrl #(.DEBOUNCE(4), .OPEN_TIMEOUT(64), .CNT_W(8)) dut (
    .clk(clk), .start(start),
    .entry_detect(entry_detect), .entry_pass(entry_pass), .entry_is_uni(entry_is_uni),
    .exit_detect(exit_detect), .exit_pass(exit_pass), .exit_is_uni(exit_is_uni),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .entry_barrier_open(entry_barrier_open), .exit_barrier_open(exit_barrier_open),
    .entry_denied(entry_denied), .gate_timeout(gate_timeout),
    .denied_count(denied_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    start = 1'b0;
    {entry_detect, entry_pass, entry_is_uni, exit_detect, exit_pass, exit_is_uni} = '0;
    {uni_is_vacated_space, is_vacated_space} = '0;
    tick(2);
    chk("rst_outputs", {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        entry_barrier_open, exit_barrier_open, entry_denied, gate_timeout}, 0);
    chk("rst_counts", {denied_count, timeout_count}, 0);
    start = 1'b1;
    tick(2);

    // uni car admitted and passes
    entry_is_uni = 1'b1;
    uni_is_vacated_space = 1'b1;
    entry_detect = 1'b1;
    tick(6);
    chk("open_early", entry_barrier_open, 0);
    tick(1);
    chk("open_lat7", entry_barrier_open, 1);
    entry_pass = 1'b1;
    tick(6);
    chk("report_open", {entry_barrier_open, car_entered}, 2'b10);
    tick(1);
    chk("car_entered", {car_entered, is_uni_car_entered, entry_barrier_open}, 3'b110);
    tick(1);
    chk("entered_1cyc", {car_entered, is_uni_car_entered}, 2'b01);
    entry_detect = 1'b0;
    entry_pass = 1'b0;
    tick(8);
    chk("idle_after", {entry_barrier_open, car_entered, entry_denied}, 0);

    // public car refused twice
    entry_is_uni = 1'b0;
    is_vacated_space = 1'b0;
    entry_detect = 1'b1;
    tick(6);
    chk("deny_early", entry_denied, 0);
    tick(1);
    chk("deny_pulse", {entry_denied, entry_barrier_open}, 2'b10);
    chk("deny_cnt1", denied_count, 1);
    tick(1);
    chk("deny_1cyc", entry_denied, 0);
    tick(10);
    chk("deny_closed", {entry_barrier_open, car_entered}, 0);
    entry_detect = 1'b0;
    tick(8);
    entry_detect = 1'b1;
    tick(7);
    chk("deny2_pulse", entry_denied, 1);
    chk("deny_cnt2", denied_count, 2);
    entry_detect = 1'b0;
    tick(8);

    // 3-cycle glitch must be filtered out
    is_vacated_space = 1'b1;
    entry_detect = 1'b1;
    tick(3);
    entry_detect = 1'b0;
    tick(12);
    chk("glitch", {entry_barrier_open, entry_denied, car_entered, gate_timeout}, 0);
    chk("glitch_cnt", denied_count, 2);

    // open barrier with no pass times out after 64 cycles
    entry_detect = 1'b1;
    tick(7);
    chk("to_open", entry_barrier_open, 1);
    tick(63);
    chk("to_still_open", {entry_barrier_open, gate_timeout}, 2'b10);
    tick(1);
    chk("to_close", {entry_barrier_open, gate_timeout, car_entered}, 3'b010);
    chk("to_cnt1", timeout_count, 1);
    tick(1);
    chk("to_1cyc", gate_timeout, 0);
    entry_detect = 1'b0;
    tick(8);

    // simultaneous entry and exit requests
    exit_is_uni = 1'b1;
    entry_detect = 1'b1;
    exit_detect = 1'b1;
    tick(7);
    chk("both_open", {entry_barrier_open, exit_barrier_open}, 2'b11);
    entry_pass = 1'b1;
    exit_pass = 1'b1;
    tick(7);
    chk("arb_entry", {car_entered, is_uni_car_entered, car_exited}, 3'b100);
    tick(1);
    chk("arb_gap", {car_entered, car_exited, exit_barrier_open}, 3'b001);
    tick(1);
    chk("arb_exit", {car_entered, car_exited, is_uni_car_exited, exit_barrier_open}, 4'b0110);
    tick(1);
    chk("exit_1cyc", car_exited, 0);
    {entry_detect, entry_pass, exit_detect, exit_pass} = '0;
    tick(8);

    // asynchronous reset while the entry barrier is open
    entry_detect = 1'b1;
    tick(7);
    chk("pre_rst_open", entry_barrier_open, 1);
    start = 1'b0;
    #2;
    chk("rst_mid_barrier", entry_barrier_open, 0);
    chk("rst_mid_counts", {denied_count, timeout_count}, 0);
    chk("rst_mid_qual", {is_uni_car_entered, is_uni_car_exited}, 0);
    entry_detect = 1'b0;
    tick(2);
    start = 1'b1;
    tick(15);
    chk("restart_quiet", {car_entered, car_exited, entry_barrier_open, entry_denied, gate_timeout}, 0);
    entry_detect = 1'b1;
    tick(7);
    chk("restart_open", entry_barrier_open, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
